// File: rtl/tempsens_sweep_ctrl_if.sv
// Record stream from the sweep controller to its consumer: one (code, average)
// record per DAC step, transferred when o_valid and i_ready are both high.
interface tempsens_sweep_ctrl_if #(
   parameter int DAC_W = 6,
   parameter int RES_W = 20
);
   logic             o_valid;
   logic             i_ready;
   logic [DAC_W-1:0] o_code;
   logic [RES_W-1:0] o_avg;

   modport master (
      output o_valid,
      output o_code,
      output o_avg,
      input  i_ready
   );

   modport slave (
      input  o_valid,
      input  o_code,
      input  o_avg,
      output i_ready
   );
endinterface

// File: rtl/tempsens_sweep_ctrl.sv
// Steps the tempsens DAC code over a programmed range, averages 2**AVG_LOG2
// conversions per code and hands out one (code, average) record per step.
module tempsens_sweep_ctrl #(
   parameter int RES_W    = 20,
   parameter int DAC_W    = 6,
   parameter int AVG_LOG2 = 2,
   parameter int SETTLE   = 3,
   parameter int TIMEOUT  = 4095
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [DAC_W-1:0] i_dac_first,
   input  logic [DAC_W-1:0] i_dac_last,
   output logic             o_busy,
   output logic [DAC_W-1:0] o_ts_dac_code,
   output logic             o_ts_start,
   input  logic             i_ts_done,
   input  logic [RES_W-1:0] i_ts_res,
   output logic             o_timeout,
   tempsens_sweep_ctrl_if.master rec
);

   localparam int ACC_W = RES_W + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(1 << AVG_LOG2);
   localparam logic [SET_W-1:0] SET_RELOAD = SET_W'(SETTLE - 1);
   localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_TRIG,
      S_WAIT,
      S_OUT
   } state_t;

   state_t           state_q;
   logic [DAC_W-1:0] code_q;
   logic [DAC_W-1:0] last_q;
   logic             down_q;
   logic [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic [SET_W-1:0] settle_q;
   logic [TMO_W-1:0] tmo_q;
   logic             busy_q;
   logic [DAC_W-1:0] ts_dac_code_q;
   logic             ts_start_q;
   logic             timeout_q;
   logic             valid_q;
   logic [DAC_W-1:0] rec_code_q;
   logic [RES_W-1:0] rec_avg_q;

   logic [ACC_W-1:0] acc_sum;
   logic [CNT_W-1:0] cnt_inc;
   logic [DAC_W-1:0] code_step;

   // Truncating mean: the accumulator is wide enough that the sum never wraps.
   function automatic logic [RES_W-1:0] avg_trunc(input logic [ACC_W-1:0] acc);
      return acc[ACC_W-1 -: RES_W];
   endfunction

   assign acc_sum   = acc_q + ACC_W'(i_ts_res);
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign code_step = down_q ? (code_q - DAC_W'(1)) : (code_q + DAC_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         code_q        <= '0;
         last_q        <= '0;
         down_q        <= 1'b0;
         acc_q         <= '0;
         cnt_q         <= '0;
         settle_q      <= '0;
         tmo_q         <= '0;
         busy_q        <= 1'b0;
         ts_dac_code_q <= '0;
         ts_start_q    <= 1'b0;
         timeout_q     <= 1'b0;
         valid_q       <= 1'b0;
         rec_code_q    <= '0;
         rec_avg_q     <= '0;
      end else begin
         ts_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  last_q        <= i_dac_last;
                  down_q        <= (i_dac_first > i_dac_last);
                  code_q        <= i_dac_first;
                  ts_dac_code_q <= i_dac_first;
                  timeout_q     <= 1'b0;
                  busy_q        <= 1'b1;
                  settle_q      <= SET_RELOAD;
                  acc_q         <= '0;
                  cnt_q         <= '0;
                  state_q       <= S_SETTLE;
               end
            end

            S_SETTLE: begin
               acc_q <= '0;
               cnt_q <= '0;
               if (settle_q == '0) begin
                  state_q <= S_TRIG;
               end else begin
                  settle_q <= settle_q - SET_W'(1);
               end
            end

            S_TRIG: begin
               ts_start_q <= 1'b1;
               tmo_q      <= TMO_RELOAD;
               state_q    <= S_WAIT;
            end

            // A done arriving on the expiry cycle is still taken as a good sample.
            S_WAIT: begin
               if (i_ts_done) begin
                  acc_q <= acc_sum;
                  cnt_q <= cnt_inc;
                  if (cnt_inc == CNT_FULL) begin
                     rec_code_q <= code_q;
                     rec_avg_q  <= avg_trunc(acc_sum);
                     valid_q    <= 1'b1;
                     state_q    <= S_OUT;
                  end else begin
                     state_q <= S_TRIG;
                  end
               end else if (tmo_q == '0) begin
                  timeout_q  <= 1'b1;
                  rec_code_q <= code_q;
                  rec_avg_q  <= '1;
                  valid_q    <= 1'b1;
                  state_q    <= S_OUT;
               end else begin
                  tmo_q <= tmo_q - TMO_W'(1);
               end
            end

            S_OUT: begin
               if (rec.i_ready) begin
                  valid_q <= 1'b0;
                  if (code_q == last_q) begin
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     code_q        <= code_step;
                     ts_dac_code_q <= code_step;
                     settle_q      <= SET_RELOAD;
                     acc_q         <= '0;
                     cnt_q         <= '0;
                     state_q       <= S_SETTLE;
                  end
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_busy        = busy_q;
   assign o_ts_dac_code = ts_dac_code_q;
   assign o_ts_start    = ts_start_q;
   assign o_timeout     = timeout_q;
   assign rec.o_valid   = valid_q;
   assign rec.o_code    = rec_code_q;
   assign rec.o_avg     = rec_avg_q;

endmodule

// File: tb/tb_tempsens_sweep_ctrl.sv
// Directed bench for tempsens_sweep_ctrl: a behavioural sensor answers each
// trigger from a queue of results; records are checked against hand-computed values.
module tb_tempsens_sweep_ctrl;
   localparam int RES_W   = 20;
   localparam int DAC_W   = 6;
   localparam int TIMEOUT = 4095;

   logic             clk = 1'b0;
   logic             reset;
   logic             i_start;
   logic [DAC_W-1:0] i_dac_first;
   logic [DAC_W-1:0] i_dac_last;
   logic             o_busy;
   logic [DAC_W-1:0] o_ts_dac_code;
   logic             o_ts_start;
   logic             i_ts_done;
   logic [RES_W-1:0] i_ts_res;
   logic             o_timeout;

   logic             sens_done;
   logic [RES_W-1:0] sens_res;
   logic             inj_done;
   logic [RES_W-1:0] inj_res;
   logic             ready_r;

   logic [RES_W-1:0] res_q[$];
   int               mute_code     = -1;
   int               sens_lat      = 3;
   int               trig_cnt      = 0;
   int               last_trig_cyc = 0;
   int               valid_cyc     = 0;
   int               cyc           = 0;
   int               n_chk         = 0;
   int               n_fail        = 0;

   tempsens_sweep_ctrl_if #(.DAC_W(DAC_W), .RES_W(RES_W)) rec_if ();

   tempsens_sweep_ctrl #(
      .RES_W(RES_W), .DAC_W(DAC_W), .AVG_LOG2(2), .SETTLE(3), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_start      (i_start),
      .i_dac_first  (i_dac_first),
      .i_dac_last   (i_dac_last),
      .o_busy       (o_busy),
      .o_ts_dac_code(o_ts_dac_code),
      .o_ts_start   (o_ts_start),
      .i_ts_done    (i_ts_done),
      .i_ts_res     (i_ts_res),
      .o_timeout    (o_timeout),
      .rec          (rec_if)
   );

   assign i_ts_done      = sens_done | inj_done;
   assign i_ts_res       = inj_done ? inj_res : sens_res;
   assign rec_if.i_ready = ready_r;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Sensor model: answers a trigger sens_lat cycles later unless its code is muted.
   initial begin
      sens_done = 1'b0;
      sens_res  = '0;
      forever begin
         @(posedge clk); #1;
         if (o_ts_start) begin
            trig_cnt++;
            last_trig_cyc = cyc;
            if (int'(o_ts_dac_code) != mute_code) begin
               repeat (sens_lat) @(posedge clk);
               #1;
               sens_done = 1'b1;
               sens_res  = (res_q.size() > 0) ? res_q.pop_front() : '0;
               @(posedge clk); #1;
               sens_done = 1'b0;
            end
         end
      end
   end

   task automatic start_sweep(input int first, input int last);
      i_start     = 1'b1;
      i_dac_first = DAC_W'(first);
      i_dac_last  = DAC_W'(last);
      @(posedge clk); #1;
      i_start     = 1'b0;
   endtask

   task automatic get_rec(input int stall, input int exp_code, input int exp_avg);
      int               n   = 0;
      int               chg = 0;
      logic [DAC_W-1:0] c0;
      logic [RES_W-1:0] a0;
      while (!rec_if.o_valid && n < 6000) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("rec_arrive", 32'(rec_if.o_valid), 32'd1);
      if (!rec_if.o_valid) return;
      valid_cyc = cyc;
      c0 = rec_if.o_code;
      a0 = rec_if.o_avg;
      repeat (stall) begin
         @(posedge clk); #1;
         if (rec_if.o_valid !== 1'b1 || rec_if.o_code !== c0 || rec_if.o_avg !== a0) chg++;
      end
      if (stall > 0) check_val("stall_stable", 32'(chg), 32'd0);
      check_val("rec_code", 32'(rec_if.o_code), 32'(exp_code));
      check_val("rec_avg", 32'(rec_if.o_avg), 32'(exp_avg));
      ready_r = 1'b1;
      @(posedge clk); #1;
      ready_r = 1'b0;
      check_val("valid_drop", 32'(rec_if.o_valid), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      logic [31:0] agg;
      agg = 32'({o_busy, o_ts_start, o_timeout, rec_if.o_valid}) |
            32'(o_ts_dac_code) | 32'(rec_if.o_code) | 32'(rec_if.o_avg);
      check_val(tag, agg, 32'd0);
   endtask

   initial begin
      int k;
      reset       = 1'b1;
      i_start     = 1'b0;
      i_dac_first = '0;
      i_dac_last  = '0;
      inj_done    = 1'b0;
      inj_res     = '0;
      ready_r     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_outputs");
      reset = 1'b0;
      @(posedge clk); #1;

      // Single point with averaging and trigger latency
      for (int i = 0; i < 4; i++) res_q.push_back(RES_W'(100 + i));
      start_sweep(10, 10);
      check_val("busy_after_start", 32'(o_busy), 32'd1);
      k = 1;
      while (!o_ts_start && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check_val("first_trig_latency", 32'(k), 32'd5);
      check_val("trig_dac_code", 32'(o_ts_dac_code), 32'd10);
      @(posedge clk); #1;
      check_val("trig_one_cycle", 32'(o_ts_start), 32'd0);
      get_rec(0, 10, 101);
      check_val("busy_after_last", 32'(o_busy), 32'd0);

      // Ascending sweep, constant result
      trig_cnt = 0;
      for (int i = 0; i < 12; i++) res_q.push_back(20'h12345);
      start_sweep(3, 5);
      get_rec(0, 3, 20'h12345);
      get_rec(0, 4, 20'h12345);
      get_rec(0, 5, 20'h12345);
      check_val("asc_trig_count", 32'(trig_cnt), 32'd12);
      check_val("asc_no_timeout", 32'(o_timeout), 32'd0);

      // Descending sweep with consumer stalls; truncation and full-scale averages
      for (int i = 0; i < 4; i++) res_q.push_back(20'd8);
      for (int i = 1; i <= 4; i++) res_q.push_back(RES_W'(i));
      for (int i = 0; i < 4; i++) res_q.push_back(20'hFFFFF);
      start_sweep(5, 3);
      get_rec(20, 5, 8);
      get_rec(20, 4, 2);
      get_rec(20, 3, 20'hFFFFF);
      check_val("desc_busy_end", 32'(o_busy), 32'd0);

      // Timeout on the middle code
      mute_code = 7;
      for (int i = 0; i < 4; i++) res_q.push_back(20'd40);
      for (int i = 0; i < 4; i++) res_q.push_back(20'd80);
      start_sweep(6, 8);
      get_rec(0, 6, 40);
      check_val("tmo_not_yet", 32'(o_timeout), 32'd0);
      get_rec(0, 7, 20'hFFFFF);
      check_val("tmo_gap", 32'(valid_cyc - last_trig_cyc), 32'(TIMEOUT));
      check_val("tmo_flag", 32'(o_timeout), 32'd1);
      get_rec(0, 8, 80);
      check_val("tmo_sticky", 32'(o_timeout), 32'd1);
      mute_code = -1;

      // Restart while busy and a spurious done during settle
      for (int i = 0; i < 8; i++) res_q.push_back(20'd5);
      start_sweep(20, 21);
      check_val("tmo_cleared", 32'(o_timeout), 32'd0);
      inj_res  = 20'hFFFFF;
      inj_done = 1'b1;
      @(posedge clk); #1;
      inj_done = 1'b0;
      start_sweep(40, 40);
      get_rec(0, 20, 5);
      check_val("busy_mid_sweep", 32'(o_busy), 32'd1);
      get_rec(0, 21, 5);
      check_val("restart_busy_end", 32'(o_busy), 32'd0);

      // Reset while a record is pending
      for (int i = 0; i < 4; i++) res_q.push_back(20'd7);
      start_sweep(1, 2);
      k = 0;
      while (!rec_if.o_valid && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      check_val("pre_reset_valid", 32'(rec_if.o_valid), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check_all_zero("reset_in_out");
      reset = 1'b0;
      res_q.delete();
      for (int i = 0; i < 4; i++) res_q.push_back(20'd9);
      @(posedge clk); #1;
      start_sweep(9, 9);
      get_rec(0, 9, 9);
      check_val("post_reset_idle", 32'(o_busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
